// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter that sits on the CPU memory bus.
// It has a one-byte holding register in front of the shifter and reports status at STATUS_ADDR.
module bus_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter logic [7:0]  DATA_ADDR    = 8'hFE,
  parameter logic [7:0]  STATUS_ADDR  = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  inout  wire  [7:0] data,
  input  logic       we,
  input  logic       oe,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        overrun_q, overrun_d;
  logic        shifting, baud_end, load, wr_hit, rd_hit;
  logic [7:0]  status;

  assign wr_hit   = we && (addr == DATA_ADDR);
  assign rd_hit   = oe && (addr == STATUS_ADDR);
  assign shifting = (state_q != IDLE);
  assign baud_end = (baud_cnt_q == BAUD_LAST);
  assign status   = {5'b0, overrun_q, hold_full_q, shifting};
  assign data     = rd_hit ? status : 8'hzz;
  assign busy     = shifting | hold_full_q;

  // Line sequencer: the shifter is reloaded from the holding register on the
  // IDLE edge or the last STOP edge. That reload gives frames with no idle gap between them.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    load       = 1'b0;
    tx         = 1'b1;
    case (state_q)
      IDLE: begin
        tx   = 1'b1;
        load = hold_full_q;
      end
      START: begin
        tx = 1'b0;
        if (baud_end) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      DATA: begin
        tx = shift_q[bit_idx_q];
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d   = STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      STOP: begin
        tx = 1'b1;
        if (baud_end) begin
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d    = IDLE;
            baud_cnt_d = '0;
            bit_idx_d  = '0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      shift_d    = hold_q;
      state_d    = START;
      baud_cnt_d = '0;
      bit_idx_d  = '0;
    end
  end

  // A write is accepted when the holding register is empty or is being emptied on this edge.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overrun_d   = overrun_q;
    if (load) hold_full_d = 1'b0;
    if (rd_hit) overrun_d = 1'b0;
    if (wr_hit) begin
      if (!hold_full_q || load) begin
        hold_d      = data;
        hold_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    hold_q  <= hold_d;
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench for bus_uart_tx: stimulus pushes the expected bytes and start cycles into a scoreboard.
// A UART monitor captures each frame on tx and compares it against that scoreboard.
module tb_bus_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr = 8'h00;
  logic       we = 1'b0;
  logic       oe = 1'b0;
  logic       drv_en = 1'b0;
  logic [7:0] drv_val = 8'h00;
  logic       tx, busy;
  tri1  [7:0] data_bus;

  assign data_bus = drv_en ? drv_val : 8'hzz;

  bus_uart_tx #(.CLKS_PER_BIT(4), .DATA_ADDR(8'hFE), .STATUS_ADDR(8'hFF)) dut (
    .clk  (clk),
    .reset(rst),
    .addr (addr),
    .data (data_bus),
    .we   (we),
    .oe   (oe),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         start;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   next_free = 0;
  int   wr_n = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Drives one write cycle; the edge it lands on is recorded in wr_n.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] v, input bit accept);
    exp_t e;
    addr = a; we = 1'b1; oe = 1'b0; drv_en = 1'b1; drv_val = v;
    @(negedge clk);
    wr_n = cyc;
    if (accept) begin
      e.b       = v;
      e.start   = (wr_n + 1 > next_free) ? wr_n + 1 : next_free;
      next_free = e.start + 40;
      sb.push_back(e);
    end
  endtask

  task automatic bus_idle();
    we = 1'b0; oe = 1'b0; drv_en = 1'b0; addr = 8'h00;
    @(negedge clk);
  endtask

  task automatic status_read(input string nm, input logic [7:0] req);
    we = 1'b0; drv_en = 1'b0; addr = 8'hFF; oe = 1'b1;
    #1 check(nm, {24'h0, data_bus}, {24'h0, req});
    @(negedge clk);
    oe = 1'b0; addr = 8'h00;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Frame monitor: reset is sampled on the rising edge, and tx is sampled mid-cycle.
  initial begin : monitor
    logic [39:0] smp;
    logic [7:0]  b;
    logic        act, r, ok_fr;
    int          cnt, st;
    exp_t        e;
    act = 1'b0; cnt = 0; st = 0; smp = '0;
    forever begin
      @(posedge clk);
      r = rst;
      @(negedge clk);
      if (r) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1; cnt = 1; st = cyc; smp = '0;
        end
      end else begin
        smp[cnt] = tx;
        cnt++;
        if (cnt == 40) begin
          act   = 1'b0;
          ok_fr = 1'b1;
          for (int k = 0; k < 10; k++)
            for (int j = 0; j < 4; j++)
              if (smp[4*k+j] !== smp[4*k]) ok_fr = 1'b0;
          if (smp[0] !== 1'b0 || smp[36] !== 1'b1) ok_fr = 1'b0;
          for (int k = 0; k < 8; k++) b[k] = smp[4 + 4*k];
          check("frame_framing", {31'h0, ok_fr}, 32'h1);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte %0h starting at cycle %0d, required no frame", b, st);
          end else begin
            e = sb.pop_front();
            check("frame_byte", {24'h0, b}, {24'h0, e.b});
            check("frame_start_cycle", st, e.start);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int n0;
    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_bus_undriven", {24'h0, data_bus}, 32'hFF);
    status_read("reset_status", 8'h00);
    bus_idle();

    // Single byte
    bus_write(8'hFE, 8'hA5, 1'b1);
    n0 = wr_n;
    bus_idle();
    wait_until(n0 + 10);
    status_read("single_status", 8'h01);
    wait_until(n0 + 40);
    check("single_busy_last", {31'h0, busy}, 32'h1);
    wait_until(n0 + 41);
    check("single_busy_fall", {31'h0, busy}, 32'h0);
    check("single_tx_idle", {31'h0, tx}, 32'h1);
    bus_idle();

    // Back-to-back
    bus_write(8'hFE, 8'h01, 1'b1);
    n0 = wr_n;
    bus_idle();
    bus_write(8'hFE, 8'h80, 1'b1);
    bus_idle();
    wait_until(n0 + 5);
    status_read("b2b_status_hold", 8'h03);
    wait_until(n0 + 42);
    check("b2b_busy_between", {31'h0, busy}, 32'h1);
    wait_until(n0 + 80);
    check("b2b_busy_last", {31'h0, busy}, 32'h1);
    wait_until(n0 + 81);
    check("b2b_busy_fall", {31'h0, busy}, 32'h0);
    bus_idle();

    // Overrun
    bus_write(8'hFE, 8'h11, 1'b1);
    n0 = wr_n;
    bus_write(8'hFE, 8'h22, 1'b1);
    bus_write(8'hFE, 8'h33, 1'b0);
    bus_idle();
    status_read("ovr_status_set", 8'h07);
    status_read("ovr_status_cleared", 8'h03);
    wait_until(n0 + 81);
    check("ovr_busy_fall", {31'h0, busy}, 32'h0);
    status_read("ovr_status_idle", 8'h00);
    bus_idle();

    // Reset mid-frame
    bus_write(8'hFE, 8'hFF, 1'b0);
    n0 = wr_n;
    bus_idle();
    wait_until(n0 + 14);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    next_free = 0;
    check("midrst_tx", {31'h0, tx}, 32'h1);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    status_read("midrst_status", 8'h00);
    repeat (60) @(negedge clk);
    check("midrst_tx_later", {31'h0, tx}, 32'h1);
    check("midrst_busy_later", {31'h0, busy}, 32'h0);

    // Address decode
    bus_write(8'h10, 8'h55, 1'b0);
    bus_idle();
    addr = 8'hFE; oe = 1'b1;
    #1 check("decode_read_data_addr", {24'h0, data_bus}, 32'hFF);
    @(negedge clk);
    addr = 8'h10;
    #1 check("decode_read_other_addr", {24'h0, data_bus}, 32'hFF);
    @(negedge clk);
    oe = 1'b0; addr = 8'h00;
    check("decode_busy", {31'h0, busy}, 32'h0);
    status_read("decode_status", 8'h00);
    repeat (50) @(negedge clk);
    check("decode_tx", {31'h0, tx}, 32'h1);
    check("decode_busy_later", {31'h0, busy}, 32'h0);

    check("scoreboard_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
